uart_rx: RTL and testbench

- 8N1 UART receiver; the receive-side counterpart of the 9600-baud transmitter.
- Samples the asynchronous serial input with 16x oversampling and majority-free mid-bit sampling.
- Presents each received byte on a parallel bus with a one-cycle valid strobe.
- Sits between the board RX pin and the command/loopback logic; in test gateware its output is wired to the transmitter's data/send for echo.

---
 rtl/uart_rx_if.sv | 10 +
 rtl/uart_rx.sv | 136 +++++++++++++
 tb/tb_uart_rx.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Parallel output bus of the UART receiver: received byte, strobes and busy flag.
interface uart_rx_if;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  modport master (output data, output valid, output frame_err, output busy);
  modport slave  (input  data, input  valid, input  frame_err, input  busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x-style oversampling, mid-bit sampling and
// break detection; results are presented on a uart_rx_if bus.
module uart_rx #(
    parameter int unsigned CLK_FREQ   = 12000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rx,
    uart_rx_if.master bus
);

    localparam int unsigned DIV = (CLK_FREQ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
    localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SW  = $clog2(OVERSAMPLE);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t          state;
    logic [1:0]      sync;
    logic [DW-1:0]   div_cnt;
    logic [SW-1:0]   samp;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            rx_s;
    logic            tick;

    assign rx_s = sync[1];
    assign tick = (div_cnt == DW'(DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            sync          <= '1;
            div_cnt       <= '0;
            samp          <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            bus.data      <= '0;
            bus.valid     <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            sync          <= {sync[0], rx};
            bus.valid     <= 1'b0;
            bus.frame_err <= 1'b0;

            // Divider held at zero while waiting so ticks stay phase-aligned to the start edge
            if (state == IDLE || state == BRK || tick)
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + DW'(1);

            case (state)
                IDLE: begin
                    bus.busy <= 1'b0;
                    samp     <= '0;
                    bit_idx  <= '0;
                    if (!rx_s) begin
                        state    <= START;
                        bus.busy <= 1'b1;
                    end
                end

                START: begin
                    if (tick) begin
                        if (samp == SW'(OVERSAMPLE / 2 - 1)) begin
                            samp <= '0;
                            if (!rx_s) begin
                                state <= DATA;
                            end else begin
                                state    <= IDLE;
                                bus.busy <= 1'b0;
                            end
                        end else begin
                            samp <= samp + SW'(1);
                        end
                    end
                end

                DATA: begin
                    if (tick) begin
                        if (samp == SW'(OVERSAMPLE - 1)) begin
                            samp    <= '0;
                            shreg   <= {rx_s, shreg[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7)
                                state <= STOP;
                        end else begin
                            samp <= samp + SW'(1);
                        end
                    end
                end

                STOP: begin
                    if (tick) begin
                        if (samp == SW'(OVERSAMPLE - 1)) begin
                            samp <= '0;
                            if (rx_s) begin
                                bus.data  <= shreg;
                                bus.valid <= 1'b1;
                                state     <= IDLE;
                                bus.busy  <= 1'b0;
                            end else begin
                                bus.frame_err <= 1'b1;
                                state         <= BRK;
                            end
                        end else begin
                            samp <= samp + SW'(1);
                        end
                    end
                end

                BRK: begin
                    if (rx_s) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end

                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames are generated in real time
// and the received bytes/strobes are compared with what the bench sent.
`timescale 1ns/1ps
module tb_uart_rx;

    // Clock chosen so the baud divider is exact (DIV = 8, 128 clk per bit)
    localparam int unsigned CLK_FREQ = 1228800;
    localparam int unsigned BAUD     = 9600;
    localparam int unsigned OS       = 16;
    localparam real CLK_NS  = 1.0e9 / CLK_FREQ;
    localparam real BIT_NS  = 1.0e9 / BAUD;
    localparam int  BIT_CLK = CLK_FREQ / BAUD;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx  = 1'b1;

    uart_rx_if bus ();

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .bus (bus)
    );

    always #(CLK_NS / 2.0) clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Monitor: records every strobe and any pulse-shape violation
    logic [7:0] got[$];
    int         got_cyc[$];
    int         cyc = 0;
    int         fe_cnt = 0;
    int         overlap = 0;
    int         stretch = 0;
    logic       prev_v = 1'b0;
    logic       prev_f = 1'b0;
    logic [7:0] last_good = 8'h00;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.valid) begin
            got.push_back(bus.data);
            got_cyc.push_back(cyc);
        end
        if (bus.frame_err) fe_cnt = fe_cnt + 1;
        if (bus.valid && bus.frame_err) overlap = overlap + 1;
        if ((bus.valid && prev_v) || (bus.frame_err && prev_f)) stretch = stretch + 1;
        prev_v = bus.valid;
        prev_f = bus.frame_err;
    end

    // Line stays at the stop-bit level afterwards; caller decides what follows
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input real baud);
        real bt;
        bt = 1.0e9 / baud;
        rx = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bt);
        end
        rx = stop_bit;
        #(bt);
    endtask

    task automatic settle();
        #(CLK_NS * 6.0);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++;
        if (bus.data !== 8'h00 || bus.valid !== 1'b0 || bus.frame_err !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_values: data=%h valid=%b ferr=%b busy=%b, want 00 0 0 0",
                     bus.data, bus.valid, bus.frame_err, bus.busy);
        end
        rst = 1'b1;
        #(BIT_NS);
    endtask

    task automatic test_single();
        int n0, f0;
        n0 = got.size();
        f0 = fe_cnt;
        send_byte(8'h55, 1'b1, BAUD);
        settle();
        last_good = 8'h55;
        tests++;
        if (got.size() - n0 != 1) begin
            fails++;
            $display("FAIL single_count: got %0d valid pulses, want 1", got.size() - n0);
        end else begin
            tests++;
            if (got[n0] !== 8'h55) begin
                fails++;
                $display("FAIL single_data: got %h, want 55", got[n0]);
            end
        end
        tests++;
        if (fe_cnt != f0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL single_flags: ferr pulses=%0d busy=%b, want 0 0", fe_cnt - f0, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        int n0, gap;
        n0 = got.size();
        send_byte(8'hA3, 1'b1, BAUD);
        send_byte(8'h0F, 1'b1, BAUD);
        settle();
        last_good = 8'h0F;
        tests++;
        if (got.size() - n0 != 2) begin
            fails++;
            $display("FAIL b2b_count: got %0d valid pulses, want 2", got.size() - n0);
        end else begin
            tests++;
            if (got[n0] !== 8'hA3 || got[n0+1] !== 8'h0F) begin
                fails++;
                $display("FAIL b2b_data: got %h %h, want a3 0f", got[n0], got[n0+1]);
            end
            gap = got_cyc[n0+1] - got_cyc[n0];
            tests++;
            if (gap < 10 * BIT_CLK - 2 || gap > 10 * BIT_CLK + 2) begin
                fails++;
                $display("FAIL b2b_gap: got %0d clk between strobes, want %0d +/-2", gap, 10 * BIT_CLK);
            end
        end
    endtask

    task automatic test_glitch();
        int n0, f0;
        n0 = got.size();
        f0 = fe_cnt;
        rx = 1'b0;
        #(2000.0);
        rx = 1'b1;
        #(BIT_NS);
        @(negedge clk);
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL glitch_busy: busy=%b one bit after glitch, want 0", bus.busy);
        end
        #(BIT_NS);
        tests++;
        if (got.size() != n0 || fe_cnt != f0) begin
            fails++;
            $display("FAIL glitch_output: valid=%0d ferr=%0d, want 0 0", got.size() - n0, fe_cnt - f0);
        end
    endtask

    task automatic test_frame_err();
        int n0, f0;
        n0 = got.size();
        f0 = fe_cnt;
        send_byte(8'hC9, 1'b0, BAUD);
        #(BIT_NS * 1.5);
        @(negedge clk);
        tests++;
        if (fe_cnt - f0 != 1 || got.size() != n0) begin
            fails++;
            $display("FAIL ferr_pulse: ferr=%0d valid=%0d, want 1 0", fe_cnt - f0, got.size() - n0);
        end
        tests++;
        if (bus.data !== last_good || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL ferr_hold: data=%h busy=%b during break, want %h 1", bus.data, bus.busy, last_good);
        end
        #(BIT_NS * 1.5);
        rx = 1'b1;
        #(BIT_NS * 2.0);
        @(negedge clk);
        tests++;
        if (fe_cnt - f0 != 1 || got.size() != n0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL ferr_break: ferr=%0d valid=%0d busy=%b after break, want 1 0 0",
                     fe_cnt - f0, got.size() - n0, bus.busy);
        end
        send_byte(8'h42, 1'b1, BAUD);
        settle();
        last_good = 8'h42;
        tests++;
        if (got.size() - n0 != 1 || (got.size() > n0 && got[n0] !== 8'h42)) begin
            fails++;
            $display("FAIL ferr_recover: %0d bytes, first=%h, want 1 byte 42", got.size() - n0,
                     (got.size() > n0) ? got[n0] : 8'hxx);
        end
    endtask

    task automatic test_reset_mid();
        int n0, f0;
        logic [7:0] b;
        b = 8'h3C;
        n0 = got.size();
        f0 = fe_cnt;
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            #(BIT_NS);
        end
        rx = b[4];
        #(BIT_NS / 2.0);
        rst = 1'b0;
        #(CLK_NS * 3.0);
        @(negedge clk);
        tests++;
        if (bus.data !== 8'h00 || bus.valid !== 1'b0 || bus.frame_err !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL midreset_values: data=%h valid=%b ferr=%b busy=%b, want 00 0 0 0",
                     bus.data, bus.valid, bus.frame_err, bus.busy);
        end
        rx = 1'b1;
        #(CLK_NS * 10.0);
        @(negedge clk);
        rst = 1'b1;
        last_good = 8'h00;
        #(BIT_NS * 2.0);
        tests++;
        if (got.size() != n0 || fe_cnt != f0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL midreset_quiet: valid=%0d ferr=%0d busy=%b, want 0 0 0",
                     got.size() - n0, fe_cnt - f0, bus.busy);
        end
        send_byte(8'h81, 1'b1, BAUD);
        settle();
        last_good = 8'h81;
        tests++;
        if (got.size() - n0 != 1 || (got.size() > n0 && got[n0] !== 8'h81)) begin
            fails++;
            $display("FAIL midreset_next: %0d bytes, first=%h, want 1 byte 81", got.size() - n0,
                     (got.size() > n0) ? got[n0] : 8'hxx);
        end
    endtask

    task automatic test_baud_tol();
        real rates[2];
        int n0, f0;
        rates[0] = BAUD * 1.03;
        rates[1] = BAUD * 0.97;
        for (int r = 0; r < 2; r++) begin
            n0 = got.size();
            f0 = fe_cnt;
            send_byte(8'h96, 1'b1, rates[r]);
            settle();
            #(BIT_NS);
            last_good = 8'h96;
            tests++;
            if (got.size() - n0 != 1 || fe_cnt != f0 || (got.size() > n0 && got[n0] !== 8'h96)) begin
                fails++;
                $display("FAIL baud_tol_%0d: bytes=%0d ferr=%0d first=%h, want 1 0 96", r,
                         got.size() - n0, fe_cnt - f0, (got.size() > n0) ? got[n0] : 8'hxx);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] exp[$];
        logic [7:0] b;
        int n0, f0;
        n0 = got.size();
        f0 = fe_cnt;
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            exp.push_back(b);
            send_byte(b, 1'b1, BAUD);
            #(BIT_NS * 0.25 * $urandom_range(0, 6));
        end
        settle();
        tests++;
        if (got.size() - n0 != exp.size() || fe_cnt != f0) begin
            fails++;
            $display("FAIL random_count: bytes=%0d ferr=%0d, want %0d 0", got.size() - n0, fe_cnt - f0, exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                tests++;
                if (got[n0+i] !== exp[i]) begin
                    fails++;
                    $display("FAIL random_data[%0d]: got %h, want %h", i, got[n0+i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_pulse_rules();
        tests++;
        if (overlap != 0 || stretch != 0) begin
            fails++;
            $display("FAIL pulse_rules: overlap=%0d stretched=%0d, want 0 0", overlap, stretch);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_baud_tol();
        test_random();
        test_pulse_rules();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
